program_mem_controller: RTL and testbench
=========================================

// Module: program_mem_controller
// PURPOSE
//  Responder side of the program-memory read handshake driven by each core's fetcher.
//  Accepts read requests from NUM_CONSUMERS fetchers and forwards them over NUM_CHANNELS
//  external program-memory channels. Returns each instruction word to the requesting fetcher.
//  Sits between the per-core fetchers and the program-memory model/DRAM port. Read-only.
// PARAMETERS
//  ADDR_BITS      8   program-memory address width (matches fetcher PROGRAM_MEM_ADDR_BITS)
//  DATA_BITS      16  instruction word width (matches fetcher PROGRAM_MEM_DATA_BITS)
//  NUM_CONSUMERS  4   number of fetchers served
//  NUM_CHANNELS   1   number of concurrent memory channels (1..NUM_CONSUMERS)
// PORTS
//  clk                    in   1                      clock, all state on rising edge
//  reset                  in   1                      asynchronous, active-low reset
//  consumer_read_valid    in   [NUM_CONSUMERS]        fetcher request, held until ready seen
//  consumer_read_address  in   [NUM_CONSUMERS][ADDR]  fetcher address, stable while valid
//  consumer_read_ready    out  [NUM_CONSUMERS]        data valid for that fetcher
//  consumer_read_data     out  [NUM_CONSUMERS][DATA]  instruction word
//  mem_read_valid         out  [NUM_CHANNELS]         channel request to memory
//  mem_read_address       out  [NUM_CHANNELS][ADDR]   channel address, held while valid
//  mem_read_ready         in   [NUM_CHANNELS]         memory response strobe, any length >=1
//  mem_read_data          in   [NUM_CHANNELS][DATA]   memory data, sampled when ready=1
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0, every channel IDLE, no claims, rr pointers 0.
//  Per-channel FSM (IDLE, WAITING, RELAYING), all outputs registered:
//   IDLE: grant one consumer with valid=1 that no channel has claimed.
//    Round-robin search starts at (last_grant+1) mod NUM_CONSUMERS.
//    On grant: latch the address into mem_read_address and set mem_read_valid=1.
//    Set the claim bit, update last_grant, go to WAITING. With no candidate, stay IDLE.
//   WAITING: hold mem_read_valid=1 and the address. When mem_read_ready=1:
//    mem_read_valid<=0; consumer_read_data[c]<=mem_read_data; consumer_read_ready[c]<=1.
//    Go to RELAYING.
//   RELAYING: hold ready/data. When consumer_read_valid[c]=0: consumer_read_ready[c]<=0.
//    Clear the claim and go to IDLE. A grant is possible next cycle, not the same cycle.
//  Latency, no contention: valid seen at edge N -> mem_read_valid=1 after edge N.
//   mem_read_ready seen at edge M -> consumer_read_ready=1 after edge M.
//  Same-cycle grants: channels resolve in ascending index order.
//   A higher channel excludes consumers granted by lower channels in the same cycle.
//   No consumer is ever served by two channels at once.
//  The consumer address is sampled only at grant; later changes are ignored until re-request.
//  mem_read_ready in IDLE or RELAYING is ignored; data stays unchanged.
//  consumer_read_data[c] keeps its last value after ready drops; it is cleared only by reset.
//  Consumer valid dropping during WAITING (protocol violation): the read still completes.
//   Ready pulses for one cycle, then the claim is released.
//  Reset mid-operation: the outstanding memory read is abandoned; a late mem_read_ready is ignored.
//  Fairness: with all consumers requesting, each consumer is granted once per
//   NUM_CONSUMERS grants on a channel.
// STRUCTURE
//  mem_ctrl_pkg: ch_state_t enum {IDLE=2'b00, WAITING=2'b01, RELAYING=2'b10}.
//   Also the shared default widths (ADDR/DATA) used by the fetcher and this block.
//  Sub-module rr_arbiter #(N): inputs req[N] and ptr; outputs grant one-hot and grant_idx.
//   Instantiated per channel, with req masked by claims from lower-index channels.
//  Top: generate loop over channels, claim vector [NUM_CONSUMERS], per-channel consumer index.
// TESTING  (default params unless noted; memory model with programmable delay)
//  1 Single fetch: consumer0 valid, addr 8'h10; memory returns 16'hABCD after 0 wait.
//    -> mem_read_address=8'h10; consumer_read_ready[0]=1 with data ABCD; ready drops after valid.
//  2 Memory delay 3: consumer1 addr 8'h20 -> mem_read_valid high for 4 cycles.
//    -> Consumer1 gets 16'h1234 exactly one cycle after mem_read_ready.
//  3 Contention: consumers 0..3 request at once (addr 00..03, data DEAD,BEEF,CAFE,5678).
//    -> Served in order 0,1,2,3; each gets its own word; never two readies in flight.
//  4 NUM_CHANNELS=2, 3 requests at once -> channel0 takes c0 and channel1 takes c1 same cycle.
//    -> c2 is served by whichever channel frees first; no double claim (assertion).
//  5 Consumer holds valid 5 extra cycles after ready -> ready stays 1, no new mem request.
//    -> After valid drops: ready=0 next cycle and the claim clears.
//  6 Reset mid-WAITING (addr 8'hFF), then late mem_read_ready.
//    -> All outputs 0 immediately; late response ignored; next fetch 8'h7F -> 16'h8888 correct.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared widths, channel state encoding and index-width helper
package mem_ctrl_pkg;
  // Default widths shared with the per-core fetchers.
  localparam int DEFAULT_ADDR_BITS = 8;
  localparam int DEFAULT_DATA_BITS = 16;
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAITING  = 2'b01,
    RELAYING = 2'b10
  } ch_state_t;
  // Width of an index into n items, never narrower than one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/program_mem_controller_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of one requester
//  req       in   [N]   requesters eligible this cycle
//  ptr       in   [IW]  index searched first; search wraps upward from here
//  grant     out  [N]   one-hot winner, zero when nothing requests
//  grant_idx out  [IW]  index of the winner, zero when nothing requests
module rr_arbiter import mem_ctrl_pkg::*; #(
  parameter int N = 4,
  localparam int IW = idx_bits(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);
  logic found;
  // Walk from the farthest offset back to ptr so the nearest requester wins.
  always_comb begin
    found = 1'b0;
    grant_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        found = 1'b1;
        grant_idx = IW'((int'(ptr) + i) % N);
      end
    end
    grant = found ? (N'(1) << grant_idx) : '0;
  end
endmodule

// File: rtl/program_mem_controller.sv
// program_mem_controller: relays fetcher program-memory reads over shared memory channels
//  clk                    in   clock, all state on rising edge
//  reset                  in   asynchronous active-low reset
//  consumer_read_valid    in   [NUM_CONSUMERS]        fetcher request, held until ready
//  consumer_read_address  in   [NUM_CONSUMERS][ADDR]  fetcher address
//  consumer_read_ready    out  [NUM_CONSUMERS]        instruction word valid for that fetcher
//  consumer_read_data     out  [NUM_CONSUMERS][DATA]  instruction word, kept until next read
//  mem_read_valid         out  [NUM_CHANNELS]         channel request to memory
//  mem_read_address       out  [NUM_CHANNELS][ADDR]   channel address, held while valid
//  mem_read_ready         in   [NUM_CHANNELS]         memory response strobe
//  mem_read_data          in   [NUM_CHANNELS][DATA]   memory data, sampled with ready
module program_mem_controller import mem_ctrl_pkg::*; #(
  parameter int ADDR_BITS     = DEFAULT_ADDR_BITS,
  parameter int DATA_BITS     = DEFAULT_DATA_BITS,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
  output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data
);
  localparam int CW = idx_bits(NUM_CONSUMERS);
  logic [NUM_CONSUMERS-1:0]                   claim;
  // taken[g] = consumers unavailable to channel g: claimed, or granted by a lower channel now.
  logic [NUM_CHANNELS:0][NUM_CONSUMERS-1:0]   taken;
  logic [NUM_CHANNELS-1:0][NUM_CONSUMERS-1:0] grant;
  logic [NUM_CHANNELS-1:0][CW-1:0]            ch_idx;
  logic [NUM_CHANNELS-1:0]                    ch_done;
  logic [NUM_CHANNELS-1:0]                    ch_release;
  assign taken[0] = claim;
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    ch_state_t                state;
    ch_state_t                state_nxt;
    logic [CW-1:0]            rr_ptr;
    logic [CW-1:0]            idx;
    logic [CW-1:0]            gnt_idx;
    logic [NUM_CONSUMERS-1:0] req;
    logic                     gnt;
    logic                     valid_q;
    logic [ADDR_BITS-1:0]     addr_q;
    assign req = (state == IDLE) ? (consumer_read_valid & ~taken[g]) : '0;
    rr_arbiter #(.N(NUM_CONSUMERS)) u_arb (
      .req       (req),
      .ptr       (rr_ptr),
      .grant     (grant[g]),
      .grant_idx (gnt_idx)
    );
    assign gnt            = |grant[g];
    assign taken[g+1]     = taken[g] | grant[g];
    assign ch_done[g]     = (state == WAITING) && mem_read_ready[g];
    // Release waits for the fetcher to drop valid; a grant can follow next cycle.
    assign ch_release[g]  = (state == RELAYING) && !consumer_read_valid[idx];
    assign ch_idx[g]           = idx;
    assign mem_read_valid[g]   = valid_q;
    assign mem_read_address[g] = addr_q;
    always_comb begin
      state_nxt = state;
      state_nxt = gnt ? WAITING : ch_done[g] ? RELAYING : ch_release[g] ? IDLE : state;
    end
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state   <= IDLE;
        rr_ptr  <= '0;
        idx     <= '0;
        valid_q <= 1'b0;
        addr_q  <= '0;
      end else begin
        state <= state_nxt;
        if (gnt) begin
          idx     <= gnt_idx;
          rr_ptr  <= CW'((int'(gnt_idx) + 1) % NUM_CONSUMERS);
          valid_q <= 1'b1;
          addr_q  <= consumer_read_address[gnt_idx];
        end
        if (ch_done[g]) valid_q <= 1'b0;
      end
    end
  end
  // Claims and consumer-side outputs; at most one channel ever owns a given consumer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      claim               <= '0;
      consumer_read_ready <= '0;
      consumer_read_data  <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        for (int c = 0; c < NUM_CONSUMERS; c++) begin
          if (grant[ch][c]) claim[c] <= 1'b1;
          if (ch_idx[ch] == CW'(c)) begin
            if (ch_done[ch]) begin
              consumer_read_ready[c] <= 1'b1;
              consumer_read_data[c]  <= mem_read_data[ch];
            end
            if (ch_release[ch]) begin
              consumer_read_ready[c] <= 1'b0;
              claim[c]               <= 1'b0;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_program_mem_controller.sv
// tb_program_mem_controller: vector table plus directed sequences, scoreboarded read data
module tb_program_mem_controller;
  logic clk;
  logic rst_n;
  int total = 0;
  int bad = 0;
  logic [15:0] mem [256];
  int mem_delay = 0;
  bit inject = 0;
  // Single-channel instance
  logic [3:0]       a_cv, a_cr;
  logic [3:0][7:0]  a_ca;
  logic [3:0][15:0] a_cd;
  logic [0:0]       a_mv, a_mr;
  logic [0:0][7:0]  a_ma;
  logic [0:0][15:0] a_md;
  int a_cnt = 0;
  // Two-channel instance
  logic [3:0]       b_cv, b_cr;
  logic [3:0][7:0]  b_ca;
  logic [3:0][15:0] b_cd;
  logic [1:0]       b_mv, b_mr;
  logic [1:0][7:0]  b_ma;
  logic [1:0][15:0] b_md;
  int b_cnt [2];
  int b_delay [2];
  program_mem_controller #(.NUM_CHANNELS(1)) dut_a (
    .clk(clk), .reset(rst_n),
    .consumer_read_valid(a_cv), .consumer_read_address(a_ca),
    .consumer_read_ready(a_cr), .consumer_read_data(a_cd),
    .mem_read_valid(a_mv), .mem_read_address(a_ma),
    .mem_read_ready(a_mr), .mem_read_data(a_md)
  );
  program_mem_controller #(.NUM_CHANNELS(2)) dut_b (
    .clk(clk), .reset(rst_n),
    .consumer_read_valid(b_cv), .consumer_read_address(b_ca),
    .consumer_read_ready(b_cr), .consumer_read_data(b_cd),
    .mem_read_valid(b_mv), .mem_read_address(b_ma),
    .mem_read_ready(b_mr), .mem_read_data(b_md)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct { int c; logic [15:0] d; } sb_t;
  typedef struct { int c; logic [7:0] a; logic [15:0] d; int dly; int hold; } vec_t;
  sb_t sb[$];
  vec_t vecs[4];
  logic [3:0] a_prev = '0;
  int sb_idx;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  // Memory models: respond after mem_delay idle cycles, ready one cycle wide.
  always @(negedge clk) begin
    if (!rst_n) begin
      a_mr = '0;
      a_cnt = 0;
    end else if (inject) begin
      a_mr = 1'b1;
      a_md[0] = 16'hDEAD;
    end else if (a_mv[0] && !a_mr[0]) begin
      if (a_cnt == mem_delay) begin
        a_mr = 1'b1;
        a_md[0] = mem[a_ma[0]];
        a_cnt = 0;
      end else a_cnt++;
    end else a_mr = 1'b0;
  end
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        b_mr[k] = 1'b0;
        b_cnt[k] = 0;
      end else if (b_mv[k] && !b_mr[k]) begin
        if (b_cnt[k] == b_delay[k]) begin
          b_mr[k] = 1'b1;
          b_md[k] = mem[b_ma[k]];
          b_cnt[k] = 0;
        end else b_cnt[k]++;
      end else b_mr[k] = 1'b0;
    end
  end
  // Scoreboard: each rising consumer ready pops the oldest expected word for that consumer.
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (a_cr[c] && !a_prev[c]) begin
        sb_idx = -1;
        for (int k = sb.size() - 1; k >= 0; k--) if (sb[k].c == c) sb_idx = k;
        if (sb_idx < 0) check("sb_unexpected_ready", 32'(c), 32'hFFFF_FFFF);
        else begin
          check("sb_data", a_cd[c], sb[sb_idx].d);
          sb.delete(sb_idx);
        end
      end
    end
    a_prev = a_cr;
  end
  task automatic fetch(input int c, input logic [7:0] a, input int hold);
    int cyc;
    bit got;
    bit ok;
    a_ca[c] = a;
    a_cv[c] = 1'b1;
    sb.push_back('{c, mem[a]});
    cyc = 0;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      if (i == 0) begin
        check("grant_valid", a_mv[0], 1);
        check("grant_addr", a_ma[0], a);
        a_ca[c] = ~a;
      end
      got = a_cr[c];
      if (!got && a_mv[0]) cyc++;
    end
    check("ready_seen", got, 1);
    check("mem_valid_cycles", cyc, mem_delay + 1);
    check("mem_valid_drop", a_mv[0], 0);
    check("data", a_cd[c], mem[a]);
    ok = 1;
    for (int h = 0; h < hold; h++) begin
      if (h == 0) inject = 1;
      tick();
      inject = 0;
      ok = ok && a_cr[c] && !a_mv[0] && (a_cd[c] == mem[a]);
    end
    if (hold > 0) check("hold_ready", ok, 1);
    a_cv[c] = 1'b0;
    tick();
    check("ready_drop", a_cr[c], 0);
    check("data_kept", a_cd[c], mem[a]);
    tick();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    a_cv = '0;
    b_cv = '0;
    #1;
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask
  int order[$];
  int multi;
  int dbl;
  bit saw;
  bit got;
  logic [2:0] served;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {i[7:0], ~i[7:0]};
    vecs[0] = '{0, 8'h10, 16'hABCD, 0, 0};
    vecs[1] = '{1, 8'h20, 16'h1234, 3, 0};
    vecs[2] = '{2, 8'h30, 16'hBEEF, 1, 5};
    vecs[3] = '{3, 8'h55, 16'h0F0F, 2, 2};
    a_cv = '0; a_ca = '0; b_cv = '0; b_ca = '0;
    b_delay[0] = 4; b_delay[1] = 1;
    rst_n = 1'b0;
    #3;
    check("reset_a_outputs", {a_cr, a_mv, a_ma[0]}, 0);
    check("reset_a_data", a_cd, 0);
    check("reset_b_outputs", {b_cr, b_mv, b_ma}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    foreach (vecs[i]) begin
      mem[vecs[i].a] = vecs[i].d;
      mem_delay = vecs[i].dly;
      fetch(vecs[i].c, vecs[i].a, vecs[i].hold);
      check("vec_data", a_cd[vecs[i].c], vecs[i].d);
    end
    // Fetcher drops valid while the memory read is still outstanding.
    mem_delay = 2;
    mem[8'h66] = 16'hC3C3;
    a_ca[1] = 8'h66;
    a_cv[1] = 1'b1;
    sb.push_back('{1, 16'hC3C3});
    tick();
    a_cv[1] = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = a_cr[1];
    end
    check("violation_ready", got, 1);
    check("violation_data", a_cd[1], 16'hC3C3);
    tick();
    check("violation_pulse", a_cr[1], 0);
    tick();
    // Contention from reset: all four at once, served 0..3.
    do_reset();
    mem_delay = 0;
    mem[0] = 16'hDEAD; mem[1] = 16'hBEEF; mem[2] = 16'hCAFE; mem[3] = 16'h5678;
    for (int c = 0; c < 4; c++) begin
      a_ca[c] = 8'(c);
      sb.push_back('{c, mem[c]});
    end
    a_cv = 4'hF;
    order.delete();
    multi = 0;
    for (int i = 0; i < 200 && order.size() < 4; i++) begin
      tick();
      if ($countones(a_cr) > 1) multi++;
      for (int c = 0; c < 4; c++) if (a_cr[c] && a_cv[c]) begin
        order.push_back(c);
        a_cv[c] = 1'b0;
      end
    end
    tick();
    tick();
    check("contention_served", order.size(), 4);
    for (int i = 0; i < 4; i++) check("contention_order", (i < order.size()) ? order[i] : -1, i);
    check("contention_single_ready", multi, 0);
    // Reset while a read is outstanding, then a stray memory response.
    mem_delay = 6;
    a_ca[0] = 8'hFF;
    a_cv[0] = 1'b1;
    tick();
    tick();
    check("pre_reset_waiting", {a_mv[0], a_ma[0]}, {1'b1, 8'hFF});
    rst_n = 1'b0;
    #1;
    check("reset_mid_outputs", {a_cr, a_mv, a_ma[0]}, 0);
    check("reset_mid_data", a_cd, 0);
    a_cv = '0;
    tick();
    rst_n = 1'b1;
    inject = 1;
    tick();
    inject = 0;
    tick();
    check("late_ready_ignored", {a_cr, a_mv}, 0);
    check("late_ready_data", a_cd, 0);
    mem_delay = 0;
    mem[8'h7F] = 16'h8888;
    fetch(0, 8'h7F, 0);
    check("post_reset_fetch", a_cd[0], 16'h8888);
    // Two channels, three requesters.
    mem[8'h40] = 16'h1111; mem[8'h41] = 16'h2222; mem[8'h42] = 16'h3333;
    for (int c = 0; c < 3; c++) b_ca[c] = 8'h40 + 8'(c);
    b_cv = 4'b0111;
    tick();
    check("dual_grant_valid", b_mv, 2'b11);
    check("dual_grant_addr", {b_ma[1], b_ma[0]}, {8'h41, 8'h40});
    served = '0;
    dbl = 0;
    saw = 0;
    for (int i = 0; i < 100 && served != 3'b111; i++) begin
      tick();
      if (b_mv == 2'b11 && b_ma[0] == b_ma[1]) dbl++;
      if (b_mv[1] && b_ma[1] == 8'h42) saw = 1;
      for (int c = 0; c < 3; c++) if (b_cr[c] && b_cv[c]) begin
        check("dual_data", b_cd[c], mem[8'h40 + c]);
        served[c] = 1'b1;
        b_cv[c] = 1'b0;
      end
    end
    check("dual_all_served", served, 3'b111);
    check("dual_c2_on_ch1", saw, 1);
    check("dual_no_double_claim", dbl, 0);
    tick();
    tick();
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
